// File: rtl/eic_ahb_regs.sv
// AHB-Lite register file for the external interrupt controller: mask, forced
// flag strobes and sense-mode selects out; pending flags and irq number in.
module eic_ahb_regs #(
  parameter int EIC_DIRECT_CHANNELS = 32,
  parameter int EIC_SENSE_CHANNELS  = 32,
  parameter int EIC_TOTAL_CHANNELS  = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS
) (
  input  logic                            CLK,
  input  logic                            RESETn,
  input  logic                            HSEL,
  input  logic [31:0]                     HADDR,
  input  logic [1:0]                      HTRANS,
  input  logic                            HWRITE,
  input  logic [2:0]                      HSIZE,
  input  logic [31:0]                     HWDATA,
  input  logic                            HREADY,
  output logic [31:0]                     HRDATA,
  output logic                            HREADYOUT,
  output logic                            HRESP,
  input  logic [EIC_TOTAL_CHANNELS-1:0]   request,
  input  logic [5:0]                      irqNumber,
  output logic [EIC_TOTAL_CHANNELS-1:0]   mask,
  output logic [EIC_TOTAL_CHANNELS-1:0]   requestWR,
  output logic [EIC_TOTAL_CHANNELS-1:0]   requestIn,
  output logic [2*EIC_SENSE_CHANNELS-1:0] senseMask
);

  localparam logic [3:0] A_EICR    = 4'd0;
  localparam logic [3:0] A_EIMSK0  = 4'd1;
  localparam logic [3:0] A_EIMSK1  = 4'd2;
  localparam logic [3:0] A_EIFR0   = 4'd3;
  localparam logic [3:0] A_EIFR1   = 4'd4;
  localparam logic [3:0] A_EIFRS0  = 4'd5;
  localparam logic [3:0] A_EIFRS1  = 4'd6;
  localparam logic [3:0] A_EIFRC0  = 4'd7;
  localparam logic [3:0] A_EIFRC1  = 4'd8;
  localparam logic [3:0] A_EISMSK0 = 4'd9;
  localparam logic [3:0] A_EISMSK1 = 4'd10;
  localparam logic [3:0] A_EIIPR   = 4'd11;

  // Internal state is kept 64 bits wide; bits beyond the configured channel
  // counts are forced to zero so they never store, read back or strobe.
  localparam logic [63:0] CH_VALID = (EIC_TOTAL_CHANNELS >= 64) ? {64{1'b1}} :
                                     ((64'd1 << EIC_TOTAL_CHANNELS) - 64'd1);
  localparam logic [63:0] SENSE_VALID = (2*EIC_SENSE_CHANNELS >= 64) ? {64{1'b1}} :
                                        ((64'd1 << (2*EIC_SENSE_CHANNELS)) - 64'd1);

  logic        eicr;
  logic [63:0] eimsk;
  logic [63:0] eismsk;
  logic [63:0] req_wr;
  logic [63:0] req_in;
  logic        data_valid;
  logic        data_write;
  logic [3:0]  data_addr;
  logic [63:0] request_ext;

  assign request_ext = 64'(request);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      eicr       <= 1'b0;
      eimsk      <= '0;
      eismsk     <= '0;
      req_wr     <= '0;
      req_in     <= '0;
      data_valid <= 1'b0;
      data_write <= 1'b0;
      data_addr  <= '0;
    end else begin
      data_valid <= HSEL & HREADY & HTRANS[1];
      if (HSEL && HREADY && HTRANS[1]) begin
        data_write <= HWRITE;
        data_addr  <= HADDR[5:2];
      end
      // Flag strobes are single-cycle pulses following the committing edge.
      req_wr <= '0;
      req_in <= '0;
      if (data_valid && data_write) begin
        case (data_addr)
          A_EICR:    eicr <= HWDATA[0];
          A_EIMSK0:  eimsk[31:0]  <= HWDATA & CH_VALID[31:0];
          A_EIMSK1:  eimsk[63:32] <= HWDATA & CH_VALID[63:32];
          A_EIFR0: begin
            req_wr[31:0] <= CH_VALID[31:0];
            req_in[31:0] <= HWDATA & CH_VALID[31:0];
          end
          A_EIFR1: begin
            req_wr[63:32] <= CH_VALID[63:32];
            req_in[63:32] <= HWDATA & CH_VALID[63:32];
          end
          A_EIFRS0: begin
            req_wr[31:0] <= HWDATA & CH_VALID[31:0];
            req_in[31:0] <= HWDATA & CH_VALID[31:0];
          end
          A_EIFRS1: begin
            req_wr[63:32] <= HWDATA & CH_VALID[63:32];
            req_in[63:32] <= HWDATA & CH_VALID[63:32];
          end
          A_EIFRC0:  req_wr[31:0]  <= HWDATA & CH_VALID[31:0];
          A_EIFRC1:  req_wr[63:32] <= HWDATA & CH_VALID[63:32];
          A_EISMSK0: eismsk[31:0]  <= HWDATA & SENSE_VALID[31:0];
          A_EISMSK1: eismsk[63:32] <= HWDATA & SENSE_VALID[63:32];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (data_valid && !data_write) begin
      case (data_addr)
        A_EICR:    HRDATA = {31'b0, eicr};
        A_EIMSK0:  HRDATA = eimsk[31:0];
        A_EIMSK1:  HRDATA = eimsk[63:32];
        A_EIFR0:   HRDATA = request_ext[31:0];
        A_EIFR1:   HRDATA = request_ext[63:32];
        A_EISMSK0: HRDATA = eismsk[31:0];
        A_EISMSK1: HRDATA = eismsk[63:32];
        A_EIIPR:   HRDATA = {26'b0, irqNumber};
        default:   HRDATA = '0;
      endcase
    end
  end

  // Clearing the global enable gates every channel but keeps EIMSK intact.
  assign mask      = eimsk[EIC_TOTAL_CHANNELS-1:0] & {EIC_TOTAL_CHANNELS{eicr}};
  assign requestWR = req_wr[EIC_TOTAL_CHANNELS-1:0];
  assign requestIn = req_in[EIC_TOTAL_CHANNELS-1:0];
  assign senseMask = eismsk[2*EIC_SENSE_CHANNELS-1:0];
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:6], HADDR[1:0], HTRANS[0], HSIZE,
                       eimsk, eismsk, req_wr, req_in, request_ext};

endmodule

// File: tb/tb_eic_ahb_regs.sv
// Self-checking bench for eic_ahb_regs: directed register-map scenarios plus
// randomized AHB traffic checked against a register-level reference model.
module tb_eic_ahb_regs;

  localparam int DIRECT = 32;
  localparam int SENSE  = 32;
  localparam int TOTAL  = DIRECT + SENSE;

  logic              CLK;
  logic              RESETn;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;
  logic [TOTAL-1:0]  request;
  logic [5:0]        irqNumber;
  logic [TOTAL-1:0]  mask;
  logic [TOTAL-1:0]  requestWR;
  logic [TOTAL-1:0]  requestIn;
  logic [2*SENSE-1:0] senseMask;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents only.
  logic        m_eicr;
  logic [63:0] m_eimsk;
  logic [63:0] m_sense;

  eic_ahb_regs #(
    .EIC_DIRECT_CHANNELS(DIRECT),
    .EIC_SENSE_CHANNELS (SENSE)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .request(request), .irqNumber(irqNumber), .mask(mask),
    .requestWR(requestWR), .requestIn(requestIn), .senseMask(senseMask)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Bus driver tasks start and end at a falling edge.
  task automatic drive_addr(input logic [3:0] idx, input logic wr);
    logic [31:0] r;
    r = $urandom();
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE  = 3'($urandom_range(0, 2));
    HADDR  = {r[31:6], idx, r[1:0]};
  endtask

  task automatic drive_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = $urandom();
  endtask

  task automatic bus_write(input logic [3:0] idx, input logic [31:0] data);
    drive_addr(idx, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    drive_idle();
    HWDATA = data;
    @(posedge CLK);
    @(negedge CLK);
    HWDATA = $urandom();
  endtask

  task automatic bus_read(input logic [3:0] idx, output logic [31:0] data);
    drive_addr(idx, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    data = HRDATA;
    drive_idle();
    HWDATA = $urandom();
  endtask

  task automatic apply_reset();
    RESETn = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    m_eicr  = 1'b0;
    m_eimsk = '0;
    m_sense = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] idx);
    logic [63:0] req;
    req = request;
    case (idx)
      4'd0:  return {31'b0, m_eicr};
      4'd1:  return m_eimsk[31:0];
      4'd2:  return m_eimsk[63:32];
      4'd3:  return req[31:0];
      4'd4:  return req[63:32];
      4'd9:  return m_sense[31:0];
      4'd10: return m_sense[63:32];
      4'd11: return {26'b0, irqNumber};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] idx, input logic [31:0] d,
                             output logic [63:0] wr, output logic [63:0] val);
    wr  = '0;
    val = '0;
    case (idx)
      4'd0:  m_eicr = d[0];
      4'd1:  m_eimsk[31:0]  = d;
      4'd2:  m_eimsk[63:32] = d;
      4'd3:  begin wr[31:0]  = '1; val[31:0]  = d; end
      4'd4:  begin wr[63:32] = '1; val[63:32] = d; end
      4'd5:  begin wr[31:0]  = d;  val[31:0]  = d; end
      4'd6:  begin wr[63:32] = d;  val[63:32] = d; end
      4'd7:  wr[31:0]  = d;
      4'd8:  wr[63:32] = d;
      4'd9:  m_sense[31:0]  = d;
      4'd10: m_sense[63:32] = d;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp;
    logic [63:0] req;
    request   = {$urandom(), $urandom()};
    irqNumber = 6'($urandom_range(1, 63));
    apply_reset();
    n_checks++;
    if (mask !== '0) begin n_fail++; $display("[TB] FAIL reset_mask: got %h expected 0", mask); end
    n_checks++;
    if (senseMask !== '0) begin n_fail++; $display("[TB] FAIL reset_sense: got %h expected 0", senseMask); end
    n_checks++;
    if (requestWR !== '0 || requestIn !== '0) begin
      n_fail++; $display("[TB] FAIL reset_strobes: got wr=%h in=%h expected 0", requestWR, requestIn);
    end
    n_checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bus_resp: got ready=%b resp=%b expected 1/0", HREADYOUT, HRESP);
    end
    req = request;
    for (int i = 0; i < 16; i++) begin
      bus_read(4'(i), rd);
      exp = (i == 3) ? req[31:0] : (i == 4) ? req[63:32] : (i == 11) ? {26'b0, irqNumber} : 32'h0;
      n_checks++;
      if (rd !== exp) begin n_fail++; $display("[TB] FAIL reset_read[%0d]: got %h expected %h", i, rd, exp); end
    end
  endtask

  task automatic test_mask_enable();
    logic [31:0] rd;
    bus_write(4'd1, 32'h0000_00F0);
    n_checks++;
    if (mask !== '0) begin n_fail++; $display("[TB] FAIL mask_disabled: got %h expected 0", mask); end
    bus_write(4'd0, 32'h0000_0001);
    n_checks++;
    if (mask !== 64'h0000_0000_0000_00F0) begin
      n_fail++; $display("[TB] FAIL mask_enabled: got %h expected 00000000000000f0", mask);
    end
    bus_write(4'd0, 32'hFFFF_FFFE);
    n_checks++;
    if (mask !== '0) begin n_fail++; $display("[TB] FAIL mask_reenable_off: got %h expected 0", mask); end
    bus_read(4'd1, rd);
    n_checks++;
    if (rd !== 32'h0000_00F0) begin n_fail++; $display("[TB] FAIL eimsk0_kept: got %h expected 000000f0", rd); end
    bus_read(4'd0, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL eicr_read: got %h expected 0", rd); end
  endtask

  task automatic test_flag_strobes();
    bus_write(4'd5, 32'h0000_0005);
    n_checks++;
    if (requestWR !== 64'h5 || requestIn !== 64'h5) begin
      n_fail++; $display("[TB] FAIL eifrs0_pulse: got wr=%h in=%h expected 5/5", requestWR, requestIn);
    end
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (requestWR !== '0 || requestIn !== '0) begin
      n_fail++; $display("[TB] FAIL eifrs0_one_cycle: got wr=%h in=%h expected 0/0", requestWR, requestIn);
    end
    bus_write(4'd7, 32'h0000_0001);
    n_checks++;
    if (requestWR !== 64'h1 || requestIn !== 64'h0) begin
      n_fail++; $display("[TB] FAIL eifrc0_pulse: got wr=%h in=%h expected 1/0", requestWR, requestIn);
    end
    bus_write(4'd4, 32'h8000_0001);
    n_checks++;
    if (requestWR !== 64'hFFFF_FFFF_0000_0000 || requestIn !== 64'h8000_0001_0000_0000) begin
      n_fail++; $display("[TB] FAIL eifr1_pulse: got wr=%h in=%h expected ffffffff00000000/8000000100000000",
                         requestWR, requestIn);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    // Write EISMSK0 immediately followed by a read of it.
    drive_addr(4'd9, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    HWDATA = 32'h0000_000C;
    drive_addr(4'd9, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (HRDATA !== 32'h0000_000C) begin n_fail++; $display("[TB] FAIL b2b_read: got %h expected 0000000c", HRDATA); end
    n_checks++;
    if (senseMask[3:2] !== 2'b11 || senseMask !== 64'hC) begin
      n_fail++; $display("[TB] FAIL b2b_sense: got %h expected c", senseMask);
    end
    drive_idle();
    // Two consecutive flag writes must produce two consecutive pulses.
    a = $urandom();
    b = $urandom();
    drive_addr(4'd5, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    HWDATA = a;
    drive_addr(4'd8, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    HWDATA = b;
    drive_idle();
    n_checks++;
    if (requestWR !== {32'h0, a} || requestIn !== {32'h0, a}) begin
      n_fail++; $display("[TB] FAIL b2b_pulse1: got wr=%h in=%h expected %h", requestWR, requestIn, a);
    end
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (requestWR !== {b, 32'h0} || requestIn !== '0) begin
      n_fail++; $display("[TB] FAIL b2b_pulse2: got wr=%h in=%h expected %h00000000/0", requestWR, requestIn, b);
    end
    @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (requestWR !== '0) begin n_fail++; $display("[TB] FAIL b2b_pulse_end: got %h expected 0", requestWR); end
  endtask

  task automatic test_reset_and_ignored();
    logic [31:0] rd;
    apply_reset();
    drive_addr(4'd1, 1'b1);
    @(posedge CLK);
    @(negedge CLK);
    drive_idle();
    HWDATA = 32'hDEAD_BEEF;
    RESETn = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    bus_read(4'd1, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_discard: got %h expected 0", rd); end
    // BUSY transfer with write data must not land.
    HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h8;
    @(posedge CLK);
    @(negedge CLK);
    drive_idle();
    HWDATA = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    bus_read(4'd2, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL busy_ignored: got %h expected 0", rd); end
    irqNumber = 6'd37;
    bus_read(4'd11, rd);
    n_checks++;
    if (rd !== 32'h0000_0025) begin n_fail++; $display("[TB] FAIL eiipr: got %h expected 00000025", rd); end
  endtask

  task automatic test_random();
    logic [31:0] d, rd, exp;
    logic [63:0] ewr, ein;
    logic [3:0]  idx;
    int          op;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      request   = {$urandom(), $urandom()};
      irqNumber = 6'($urandom_range(0, 63));
      idx = 4'($urandom_range(0, 15));
      d   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      op  = $urandom_range(0, 4);
      if (op <= 1) begin
        bus_write(idx, d);
        model_write(idx, d, ewr, ein);
        n_checks++;
        if (requestWR !== ewr || requestIn !== ein) begin
          n_fail++; $display("[TB] FAIL rand_strobe idx=%0d: got wr=%h in=%h expected %h/%h",
                             idx, requestWR, requestIn, ewr, ein);
        end
        n_checks++;
        if (mask !== (m_eicr ? m_eimsk : 64'h0) || senseMask !== m_sense) begin
          n_fail++; $display("[TB] FAIL rand_outputs idx=%0d: got mask=%h sense=%h expected %h/%h",
                             idx, mask, senseMask, m_eicr ? m_eimsk : 64'h0, m_sense);
        end
      end else if (op <= 3) begin
        exp = model_read(idx);
        bus_read(idx, rd);
        n_checks++;
        if (rd !== exp) begin n_fail++; $display("[TB] FAIL rand_read idx=%0d: got %h expected %h", idx, rd, exp); end
        n_checks++;
        if (requestWR !== '0) begin n_fail++; $display("[TB] FAIL rand_quiet: got %h expected 0", requestWR); end
      end else begin
        // Write-looking address phase that must not be accepted.
        drive_addr(idx, 1'b1);
        case ($urandom_range(0, 2))
          0: HTRANS = 2'b01;
          1: HSEL   = 1'b0;
          default: HREADY = 1'b0;
        endcase
        @(posedge CLK);
        @(negedge CLK);
        HREADY = 1'b1;
        drive_idle();
        HWDATA = d;
        @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (requestWR !== '0 || mask !== (m_eicr ? m_eimsk : 64'h0) || senseMask !== m_sense) begin
          n_fail++; $display("[TB] FAIL rand_ignored idx=%0d: got wr=%h mask=%h sense=%h", idx, requestWR, mask, senseMask);
        end
      end
    end
  endtask

  initial begin
    RESETn    = 1'b0;
    HSEL      = 1'b0;
    HADDR     = '0;
    HTRANS    = 2'b00;
    HWRITE    = 1'b0;
    HSIZE     = 3'b010;
    HWDATA    = '0;
    HREADY    = 1'b1;
    request   = '0;
    irqNumber = '0;
    m_eicr    = 1'b0;
    m_eimsk   = '0;
    m_sense   = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    test_reset();
    test_mask_enable();
    test_flag_strobes();
    test_back_to_back();
    test_reset_and_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
